// File: rtl/fpu_addsub_issue.sv
// fpu_addsub_issue: issue and writeback controller for the 5-stage pipelined
// FP add/sub unit. Requests come in on a valid/ready handshake and go straight
// to the unit. A tag shift register follows each operation through the unit.
// Results collect in an in-order FIFO that drains to writeback on a second
// valid/ready handshake. The unit cannot stall, so issue is credit-limited:
// in-flight plus buffered results never exceed the FIFO depth.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (req_ready from registers)
//   req_op, req_a, req_b, req_tag   operation, operands, destination tag
//   flush                           discard all buffered and in-flight results
//   fpu_start, fpu_add_sub,
//   fpu_a, fpu_b                    unit inputs (pass-through, unregistered)
//   fpu_ready, fpu_result           unit outputs
//   wb_valid/wb_ready               writeback handshake
//   wb_result, wb_tag               FIFO head
//   busy                            anything in flight or buffered
//   seq_err                         sticky: unit result stream disagrees with tracking
module fpu_addsub_issue #(
    parameter int unsigned RES_DEPTH = 8,
    parameter int unsigned TAG_W     = 5,
    parameter int unsigned LATENCY   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             fpu_start,
    output logic             fpu_add_sub,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    input  logic             fpu_ready,
    input  logic [31:0]      fpu_result,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_result,
    output logic [TAG_W-1:0] wb_tag,
    output logic             busy,
    output logic             seq_err
);

    localparam int unsigned CNT_W = $clog2(RES_DEPTH + 1);
    localparam int unsigned INF_W = $clog2(LATENCY + 1);
    localparam int unsigned SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;
    localparam int unsigned PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

    typedef struct packed {
        logic             v;
        logic             kill;
        logic [TAG_W-1:0] tag;
    } sr_ent_t;

    typedef struct packed {
        logic [31:0]      result;
        logic [TAG_W-1:0] tag;
    } res_ent_t;

    sr_ent_t    sr_q   [LATENCY];
    sr_ent_t    sr_d   [LATENCY];
    res_ent_t   mem_q  [RES_DEPTH];
    res_ent_t   mem_d  [RES_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
    logic [INF_W-1:0] inflight_q, inflight_d;
    logic             seq_err_q, seq_err_d;

    logic fire;
    logic retire;
    logic push;
    logic overflow;
    logic do_push;
    logic pop;

    // Credit check: every accepted request must have a FIFO slot waiting for it.
    assign req_ready = ((SUM_W'(inflight_q) + SUM_W'(fifo_count_q)) < SUM_W'(RES_DEPTH)) && !flush;
    assign fire      = req_valid & req_ready;

    // Unit drive is a straight pass-through of the request.
    assign fpu_start   = fire;
    assign fpu_add_sub = req_op;
    assign fpu_a       = req_a;
    assign fpu_b       = req_b;

    // Writeback view of the FIFO head.
    assign wb_valid  = (fifo_count_q != '0);
    assign wb_result = mem_q[rd_ptr_q].result;
    assign wb_tag    = mem_q[rd_ptr_q].tag;

    assign busy    = (inflight_q != '0) || (fifo_count_q != '0);
    assign seq_err = seq_err_q;

    // Retire/push/pop decode; flush suppresses both the push and the pop.
    always_comb begin
        retire   = sr_q[LATENCY-1].v;
        push     = retire & ~sr_q[LATENCY-1].kill & ~flush;
        overflow = push & (fifo_count_q == CNT_W'(RES_DEPTH));
        do_push  = push & ~overflow;
        pop      = wb_valid & wb_ready & ~flush;
    end

    // Tag shift register: new entry at slot 0, flush marks every live entry killed.
    always_comb begin
        sr_d[0] = '{v: fire, kill: 1'b0, tag: req_tag};
        for (int unsigned i = 1; i < LATENCY; i++) begin
            sr_d[i] = sr_q[i-1];
        end
        for (int unsigned i = 0; i < LATENCY; i++) begin
            sr_d[i].kill = sr_d[i].kill | (flush & sr_d[i].v);
        end
    end

    // Result FIFO storage and pointers.
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = '{result: fpu_result, tag: sr_q[LATENCY-1].tag};
            wr_ptr_d = (wr_ptr_q == PTR_W'(RES_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(RES_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        fifo_count_d = fifo_count_q + CNT_W'(do_push) - CNT_W'(pop);

        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fifo_count_d = '0;
        end
    end

    // In-flight credit count; killed entries hold their credit until they retire.
    always_comb begin
        inflight_d = inflight_q + INF_W'(fire) - INF_W'(retire);
    end

    // Sticky error: unit ready out of step with tracking, or a push into a full FIFO.
    always_comb begin
        seq_err_d = seq_err_q | (fpu_ready != retire) | overflow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                sr_q[i] <= '0;
            end
            for (int unsigned i = 0; i < RES_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            inflight_q   <= '0;
            seq_err_q    <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            inflight_q   <= inflight_d;
            seq_err_q    <= seq_err_d;
        end
    end

endmodule

// File: doc/fpu_addsub_issue.md
# fpu_addsub_issue

Issue and writeback controller for the 5-stage pipelined FP add/sub unit. Accepts tagged requests on a valid/ready handshake, drives the unit's `start`/operand inputs, and tracks each in-flight operation with a tag shift register matched to the unit's latency. It captures results into an in-order result FIFO and presents them to writeback on a second valid/ready handshake. The unit cannot stall, so credit-based issue control guarantees that no result is ever dropped.

## Interface
- `RES_DEPTH`, 8: result FIFO depth; also the total credit count (in-flight plus buffered).
- `TAG_W`, 5: width of the destination tag.
- `LATENCY`, 5: depth of the unit's valid chain; the tag shift register has this depth.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the request is accepted when `req_valid & req_ready` at a rising edge (fire).
- `req_op` in 1: 0 = add, 1 = subtract.
- `req_a`, `req_b` in 32: IEEE-754 single-precision operands.
- `req_tag` in TAG_W: destination tag.
- `flush` in 1: synchronous; discards all buffered and in-flight results.
- `fpu_start` out 1: to the unit's `start`.
- `fpu_add_sub` out 1: to the unit's `add_sub`.
- `fpu_a`, `fpu_b` out 32: to the unit's operands.
- `fpu_ready` in 1: from the unit's `ready`.
- `fpu_result` in 32: from the unit's `result`.
- `wb_valid` out 1: FIFO head is valid.
- `wb_ready` in 1: writeback accepts the head.
- `wb_result` out 32: head result.
- `wb_tag` out TAG_W: head tag.
- `busy` out 1: any operation is in flight or buffered.
- `seq_err` out 1: sticky; the unit's result stream does not match tracking.

## Operation
- State consists of:
  - Tag shift register `sr[0..LATENCY-1]`, each entry holding {v, kill, tag}.
  - Result FIFO of `RES_DEPTH` entries, each holding {result, tag}, with `fifo_count`.
  - `inflight` counter, equal to the number of set v bits in `sr`.
- `req_ready` is combinational from registers: `(inflight + fifo_count < RES_DEPTH) && !flush`.
- `fpu_start` is combinational: `req_valid & req_ready`.
- `fpu_a`/`fpu_b`/`fpu_add_sub` pass through `req_a`/`req_b`/`req_op` unregistered.
- Every edge, `sr` shifts by one:
  - `sr[0]` loads {fire, 0, req_tag}.
  - `sr[LATENCY-1]` is the retiring slot.
- Retire, when `sr[LATENCY-1].v`:
  - If `kill` = 0, push {fpu_result, tag} into the FIFO.
  - If `kill` = 1, discard the result; the credit is still freed.
- Pop: a `wb_valid & wb_ready` handshake advances the FIFO head.
- `inflight` update: +1 on fire, −1 on retire; net 0 when both occur in the same cycle.
- `fifo_count` update: +1 on a non-killed retire, −1 on pop; a simultaneous push and pop leaves it unchanged.
- Overflow is impossible by the credit rule. Pushing while `fifo_count == RES_DEPTH` sets `seq_err`.
- Flush, on the edge where `flush` = 1:
  - FIFO is emptied (`fifo_count` ← 0, any pop that cycle ignored).
  - All valid `sr` entries get `kill` = 1, including the entry loaded that edge. No fire can occur because `req_ready` = 0.
  - Killed entries keep their credit until they retire.
- `seq_err` is set when `fpu_ready != sr[LATENCY-1].v` at any edge. It clears only on reset.
- `busy` = `(inflight != 0) || (fifo_count != 0)`.
- Results leave in issue order; tags are never reordered.

## Timing
- Reset values: `sr` entries all 0; `inflight` = 0; `fifo_count` = 0.
- Outputs out of reset: `wb_valid` = 0, `busy` = 0, `seq_err` = 0, `req_ready` = 1 (with `flush` = 0), `fpu_start` = 0 (with `req_valid` = 0).
- Reset asserted mid-operation drops all state immediately. The unit is reset from the same source (`rst = ~rst_n`) at top level, so no stale result returns.
- A fire at edge E0 (the unit captures stage 1 at E0) gives `fpu_ready`/`fpu_result` valid after E4, retire and FIFO push at E5, and `wb_valid` high after E5. Accept-to-writeback latency is 5 cycles.
- Throughput is one issue per cycle when `wb_ready` is held high. The default `RES_DEPTH` of 8 is at least LATENCY+1 and sustains this.
- A credit freed by a pop at edge E becomes visible in `req_ready` after E.
- `wb_*` stay stable while `wb_valid & !wb_ready`.

## Test plan
- Single add: a = 0x3F800000, b = 0x40000000, op = 0, tag = 3, `wb_ready` = 1. Required: `wb_valid` high exactly 5 cycles after accept, `wb_result` = 0x40400000, `wb_tag` = 3, `busy` low the cycle after pop.
- Backpressure: `wb_ready` = 0, offer 10 requests with tags 0–9. Required: exactly 8 accepted and `req_ready` low after the 8th. Then `wb_ready` = 1: tags 0–7 emerge in order, `req_ready` rises after the first pop, and tags 8–9 follow.
- Streaming: 20 back-to-back requests with `wb_ready` = 1. Required: `req_ready` never drops, one `wb_valid` per cycle from cycle 5, tags in order, `seq_err` = 0.
- Flush: 3 in flight, 2 buffered, then `flush` pulsed for 1 cycle. Required: `req_ready` = 0 during flush, `wb_valid` = 0 after flush, the 3 killed results never appear, `busy` clears once they retire, and a new request tagged 7 completes normally.
- Reset mid-operation: `rst_n` low for 2 cycles with 4 in flight and 2 buffered. Required: all outputs at reset values immediately, no `wb_valid` afterwards, `seq_err` = 0.
- Sequence error: force `fpu_ready` = 1 with nothing issued. Required: `seq_err` = 1 the next cycle and held until `rst_n` goes low.
